// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state enum, requester port ids and default bus widths.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// port that was not granted last.
// Ports: req[1:0] (bit0 = CPU, bit1 = debug), last (id granted last),
//        valid (some request present), id (winning port id).
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       id
);

    always_comb begin
        valid = |req;
        id    = PORT_CPU;
        unique case (req)
            2'b01:   id = PORT_CPU;
            2'b10:   id = PORT_DBG;
            2'b11:   id = ~last;
            default: id = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one data memory.
// Ports: clk, rst (sync, active-high); c_* CPU req/we/addr/wdata in,
//        gnt/rvalid/err/rdata out; d_* same for debug; mem_read/
//        mem_write/mem_addr/mem_wdata to memory, mem_rdata back; busy.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic          c_err,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic          r_id;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_last;

    logic          w_valid;
    logic          w_id;
    logic          w_gnt;
    logic          w_err;
    logic          w_rvalid;
    logic          w_mis;

    rr_pick2 u_pick (
        .req   ({d_req, c_req}),
        .last  (r_last),
        .valid (w_valid),
        .id    (w_id)
    );

    assign w_mis = (r_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= PORT_DBG;
            r_id    <= PORT_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (r_state == ST_IDLE && w_valid) begin
                r_id    <= w_id;
                r_we    <= w_id ? d_we : c_we;
                r_addr  <= w_id ? d_addr : c_addr;
                r_wdata <= w_id ? d_wdata : c_wdata;
            end
            if (r_state == ST_ISSUE) begin
                r_last <= r_id;
            end
        end
    end

    // Everything is held quiet while rst is high, even mid-transaction,
    // so an aborted read never leaks a grant or rvalid.
    always_comb begin
        w_next    = r_state;
        w_gnt     = 1'b0;
        w_err     = 1'b0;
        w_rvalid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        w_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    w_gnt = 1'b1;
                    if (w_mis) begin
                        w_err  = 1'b1;
                        w_next = ST_IDLE;
                    end else begin
                        mem_addr  = r_addr;
                        mem_wdata = r_wdata;
                        if (r_we) begin
                            mem_write = 1'b1;
                            w_next    = ST_IDLE;
                        end else begin
                            mem_read = 1'b1;
                            w_next   = ST_RDWAIT;
                        end
                    end
                end
                ST_RDWAIT: begin
                    w_rvalid = 1'b1;
                    w_next   = ST_IDLE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    assign c_gnt    = w_gnt & (r_id == PORT_CPU);
    assign d_gnt    = w_gnt & (r_id == PORT_DBG);
    assign c_err    = w_err & (r_id == PORT_CPU);
    assign d_err    = w_err & (r_id == PORT_DBG);
    assign c_rvalid = w_rvalid & (r_id == PORT_CPU);
    assign d_rvalid = w_rvalid & (r_id == PORT_DBG);
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;
    assign busy     = !rst && (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected
// grant/rvalid events, a negedge monitor pops and compares them.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_gnt, c_rvalid, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_read, mem_write, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        bit          rv;
        bit          port;
        bit          err;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_err     (c_err),
        .c_rdata   (c_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    always @(posedge clk) begin
        if (mem_read) mem_rdata <= memval(mem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    function automatic void exp_gnt(input bit port, input bit err,
                                    input bit we, input logic [31:0] a,
                                    input logic [31:0] w, input int at);
        exp_t e;
        e.rv = 1'b0; e.port = port; e.err = err; e.we = we;
        e.addr = a; e.wdata = w; e.rdata = 32'h0; e.at = at;
        sb.push_back(e);
    endfunction

    function automatic void exp_rv(input bit port, input logic [31:0] d,
                                   input int at);
        exp_t e;
        e.rv = 1'b1; e.port = port; e.err = 1'b0; e.we = 1'b0;
        e.addr = 32'h0; e.wdata = 32'h0; e.rdata = d; e.at = at;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_quiet",
                {c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err,
                 mem_read, mem_write, busy, |mem_addr, |mem_wdata,
                 |c_rdata, |d_rdata}, 32'h0);
        end else if (c_gnt || d_gnt || c_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_event",
                    {c_gnt, d_gnt, c_rvalid, d_rvalid}, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("event_kind", {c_rvalid | d_rvalid, c_gnt | d_gnt},
                    {mon_e.rv, !mon_e.rv});
                chk("event_cycle", cyc, mon_e.at);
                if (!mon_e.rv) begin
                    chk("gnt_port", {c_gnt, d_gnt},
                        mon_e.port ? 2'b01 : 2'b10);
                    chk("gnt_err", {c_err, d_err}, !mon_e.err ? 2'b00 :
                        (mon_e.port ? 2'b01 : 2'b10));
                    chk("strobes", {mem_read, mem_write}, mon_e.err ?
                        2'b00 : (mon_e.we ? 2'b01 : 2'b10));
                    chk("mem_addr", mem_addr,
                        mon_e.err ? 32'h0 : mon_e.addr);
                    chk("mem_wdata", mem_wdata,
                        mon_e.err ? 32'h0 : mon_e.wdata);
                    chk("busy_in_issue", busy, 1);
                end else begin
                    chk("rvalid_port", {c_rvalid, d_rvalid},
                        mon_e.port ? 2'b01 : 2'b10);
                    chk("rdata_winner", mon_e.port ? d_rdata : c_rdata,
                        mon_e.rdata);
                    chk("rdata_loser", mon_e.port ? c_rdata : d_rdata, 0);
                end
            end
        end else begin
            chk("idle_quiet",
                {mem_read, mem_write, c_err, d_err, |mem_addr,
                 |mem_wdata, |c_rdata, |d_rdata}, 32'h0);
        end
    end

    task automatic drive(input bit port, input bit rq, input bit we,
                         input logic [31:0] a, input logic [31:0] w);
        if (port) begin
            d_req = rq; d_we = we; d_addr = a; d_wdata = w;
        end else begin
            c_req = rq; c_we = we; c_addr = a; c_wdata = w;
        end
    endtask

    task automatic txn(input bit port, input bit we,
                       input logic [31:0] a, input logic [31:0] w);
        bit seen;
        seen = 1'b0;
        drive(port, 1'b1, we, a, w);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = port ? d_gnt : c_gnt;
        end
        chk("gnt_timeout", {31'h0, seen}, 1);
        @(posedge clk);
        #1;
        drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int t0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        gap(3);
        rst = 1'b0;
        @(negedge clk);
        chk("busy_after_reset", busy, 0);
        gap(1);

        // CPU aligned read
        t0 = cyc;
        exp_gnt(PORT_CPU, 0, 0, 32'h10, 32'h0, t0 + 1);
        exp_rv(PORT_CPU, 32'hDEADBEEF, t0 + 2);
        txn(PORT_CPU, 1'b0, 32'h10, 32'h0);
        gap(2);

        // debug misaligned read: err with gnt, no strobe, no rvalid
        t0 = cyc;
        exp_gnt(PORT_DBG, 1, 0, 32'h13, 32'h0, t0 + 1);
        txn(PORT_DBG, 1'b0, 32'h13, 32'h0);
        gap(2);

        // request withdrawn before capture
        drive(PORT_CPU, 1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        drive(PORT_CPU, 1'b0, 1'b0, 32'h0, 32'h0);
        gap(3);

        // read dropped after grant still completes
        t0 = cyc;
        exp_gnt(PORT_CPU, 0, 0, 32'h40, 32'h0, t0 + 1);
        exp_rv(PORT_CPU, 32'hA5A50040, t0 + 2);
        txn(PORT_CPU, 1'b0, 32'h40, 32'h0);
        gap(2);

        // simultaneous writes after reset: CPU first
        rst = 1'b1;
        gap(2);
        rst = 1'b0;
        gap(1);
        t0 = cyc;
        exp_gnt(PORT_CPU, 0, 1, 32'h20, 32'h11, t0 + 1);
        exp_gnt(PORT_DBG, 0, 1, 32'h24, 32'h22, t0 + 3);
        fork
            txn(PORT_CPU, 1'b1, 32'h20, 32'h11);
            txn(PORT_DBG, 1'b1, 32'h24, 32'h22);
        join
        gap(2);

        // continuous contention: strict alternation, CPU first
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                exp_gnt(PORT_CPU, 0, 1, 32'h100 + 8 * (i / 2),
                        32'hC000 + i / 2, t0 + 1 + 2 * i);
            else
                exp_gnt(PORT_DBG, 0, 1, 32'h200 + 8 * (i / 2),
                        32'hD000 + i / 2, t0 + 1 + 2 * i);
        end
        fork
            begin
                for (int j = 0; j < 4; j++)
                    txn(PORT_CPU, 1'b1, 32'h100 + 8 * j, 32'hC000 + j);
            end
            begin
                for (int k = 0; k < 4; k++)
                    txn(PORT_DBG, 1'b1, 32'h200 + 8 * k, 32'hD000 + k);
            end
        join
        gap(2);

        // reset during RDWAIT aborts the read
        t0 = cyc;
        exp_gnt(PORT_CPU, 0, 0, 32'h30, 32'h0, t0 + 1);
        txn(PORT_CPU, 1'b0, 32'h30, 32'h0);
        rst = 1'b1;
        gap(1);
        rst = 1'b0;
        @(negedge clk);
        chk("busy_after_abort", busy, 0);
        gap(1);
        t0 = cyc;
        exp_gnt(PORT_CPU, 0, 1, 32'h50, 32'h33, t0 + 1);
        exp_gnt(PORT_DBG, 0, 1, 32'h54, 32'h44, t0 + 3);
        fork
            txn(PORT_CPU, 1'b1, 32'h50, 32'h33);
            txn(PORT_DBG, 1'b1, 32'h54, 32'h44);
        join
        gap(4);

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; DW, default 32, data width.
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit: reset, synchronous and active-high.
REQ-004 Ports c_req/c_we SHALL be inputs, 1 bit each: CPU load/store request and write-enable.
REQ-005 Ports c_addr/c_wdata SHALL be inputs, AW/DW bits: CPU byte address and store data.
REQ-006 Ports c_gnt/c_rvalid/c_err SHALL be outputs, 1 bit each: CPU grant, read-data valid, and misalign error.
REQ-007 Port c_rdata SHALL be output, DW bits: CPU load data.
REQ-008 Ports d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_err, d_rdata SHALL mirror REQ-004..007 for the debug/loader requester.
REQ-009 Ports mem_read/mem_write SHALL be outputs, 1 bit each: data-memory read and write strobes.
REQ-010 Ports mem_addr/mem_wdata SHALL be outputs, AW/DW bits: data-memory address and write data.
REQ-011 Port mem_rdata SHALL be input, DW bits: data-memory read data, valid the cycle after mem_read.
REQ-012 Port busy SHALL be output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE and RDWAIT.
REQ-014 In IDLE with any req high, the FSM SHALL register the winner's id, we, addr and wdata, then move to ISSUE.
REQ-015 Arbitration SHALL be round-robin: a lone requester wins; if both request, the one not granted last wins.
REQ-016 In ISSUE, the FSM SHALL pulse the winner's gnt for exactly one cycle and drive mem_addr/mem_wdata from the registered values.
REQ-017 In ISSUE, the FSM SHALL assert mem_write if we=1, otherwise mem_read, and never both.
REQ-018 After ISSUE, a write SHALL return to IDLE and a read SHALL go to RDWAIT.
REQ-019 In RDWAIT, the FSM SHALL pulse the winner's rvalid for one cycle with rdata = mem_rdata, then return to IDLE.
REQ-020 Latency SHALL be: req seen in IDLE at cycle T -> gnt and strobe at T+1 -> rvalid at T+2 for reads.
REQ-021 Throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-022 Misaligned requests (addr[1:0] != 0) SHALL be granted with err pulsed alongside gnt, with no memory strobe, then return to IDLE.
REQ-023 The last-grant pointer SHALL update only in ISSUE.
REQ-024 A req withdrawn before capture SHALL be ignored; once captured, the transaction SHALL complete regardless of req.
REQ-025 Requests arriving during ISSUE/RDWAIT SHALL wait (no gnt) and requesters SHALL hold req, we, addr and wdata stable until gnt.
REQ-026 The non-winning port's gnt, rvalid and err SHALL stay 0, and its rdata SHALL be 0.
REQ-027 mem_addr/mem_wdata SHALL be 0 when no strobe is active.

Reset
REQ-028 While rst=1 at a clock edge, the FSM SHALL enter IDLE and the last-grant pointer SHALL be set to debug, giving the CPU first priority.
REQ-029 While rst=1, all gnt/rvalid/err/rdata outputs, mem strobes, mem_addr, mem_wdata and busy SHALL be 0.
REQ-030 A reset during ISSUE or RDWAIT SHALL abort the transaction, and no rvalid SHALL follow it.

Structure
REQ-031 Package dmem_arb_pkg SHALL hold the state enum (IDLE/ISSUE/RDWAIT), port ids (PORT_CPU=0, PORT_DBG=1) and default AW/DW.
REQ-032 Sub-module rr_pick2 SHALL be a 2-way round-robin picker with inputs req[1:0] and last, and outputs valid and id.

Verification
REQ-033 CPU-only read: c_req, c_we=0, c_addr=0x10, mem_rdata=0xDEADBEEF -> c_gnt at T+1 with mem_read=1 and mem_addr=0x10; c_rvalid at T+2 with c_rdata=0xDEADBEEF.
REQ-034 Simultaneous requests after reset: CPU write 0x20/0x11, debug write 0x24/0x22 -> CPU is granted first and debug second, with mem_write for 0x20 then 0x24.
REQ-035 Both requesting continuously for 8 transactions -> grants alternate CPU, DBG, CPU, ...; no port is starved.
REQ-036 Misaligned: d_addr=0x13 read -> d_gnt and d_err at T+1; mem_read=0; no d_rvalid.
REQ-037 rst asserted in RDWAIT -> next cycle busy=0, no rvalid; following simultaneous requests grant the CPU first.
REQ-038 req dropped in IDLE before capture -> no gnt and no strobe; req held through ISSUE then dropped -> the read still completes with rvalid.
